// File: rtl/axi_wr_slave_fe.sv
// ---------------------------------------------------------------------------
// axi_wr_slave_fe
//
// AXI write-slave front end of the AXI-to-I2C bridge. Accepts one write burst
// at a time on AW/W, forwards every data beat together with its byte address
// as a single command to the I2C master engine, counts the per-command
// completions coming back, and returns one B response per burst.
//
// Ports
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   AWVALID/AWREADY        write-address handshake
//   AWADDR/AWSIZE/AWBURST  burst start address, log2 bytes per beat, burst type
//   WVALID/WREADY          write-data handshake
//   WLAST/WADATA           last-beat flag and beat data
//   BVALID/BREADY/BRESP    write response (OKAY or SLVERR)
//   cmd_valid/cmd_ready    one-entry registered command stage to the I2C engine
//   cmd_addr/cmd_data      beat byte address and data
//   cmd_last               beat is the last of the burst
//   cmp_valid/cmp_nack     completion pulse from the engine, NACK qualifier
// ---------------------------------------------------------------------------
module axi_wr_slave_fe #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WDATA_WIDTH    = 32,
  parameter int SIZE           = 3,
  parameter int BURST_SIZE     = 2,
  parameter int RESPONSE_WIDTH = 2
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [SIZE-1:0]           AWSIZE,
  input  logic [BURST_SIZE-1:0]     AWBURST,
  input  logic                      WVALID,
  output logic                      WREADY,
  input  logic                      WLAST,
  input  logic [WDATA_WIDTH-1:0]    WADATA,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [RESPONSE_WIDTH-1:0] BRESP,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [ADDR_WIDTH-1:0]     cmd_addr,
  output logic [WDATA_WIDTH-1:0]    cmd_data,
  output logic                      cmd_last,
  input  logic                      cmp_valid,
  input  logic                      cmp_nack
);

  // Largest legal AWSIZE: one beat may not be wider than the data bus.
  localparam int MAX_SIZE = $clog2(WDATA_WIDTH / 8);
  localparam logic [8:0] BEAT_MAX = 9'd256;
  localparam logic [BURST_SIZE-1:0] BURST_INCR = BURST_SIZE'(1);
  localparam logic [RESPONSE_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESPONSE_WIDTH-1:0] RESP_SLVERR = RESPONSE_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, DATA, DRAIN, RESP} state_t;

  state_t                      state_q, state_d;
  logic                        awready_q, awready_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [SIZE-1:0]             size_q, size_d;
  logic [BURST_SIZE-1:0]       burst_q, burst_d;
  logic                        err_q, err_d;
  logic [8:0]                  issued_q, issued_d;
  logic [8:0]                  completed_q, completed_d;
  logic                        cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0]       cmd_addr_q, cmd_addr_d;
  logic [WDATA_WIDTH-1:0]      cmd_data_q, cmd_data_d;
  logic                        cmd_last_q, cmd_last_d;
  logic                        bvalid_q, bvalid_d;
  logic [RESPONSE_WIDTH-1:0]   bresp_q, bresp_d;

  logic wready;
  logic aw_hs;
  logic w_hs;
  logic cmp_hit;
  logic aw_bad;

  // The output stage can take a new beat when empty or emptying this cycle.
  assign wready  = (state_q == DATA) && (!cmd_valid_q || cmd_ready);
  assign aw_hs   = AWVALID && awready_q;
  assign w_hs    = WVALID && wready;
  assign cmp_hit = cmp_valid && ((state_q == DATA) || (state_q == DRAIN));
  // WRAP and reserved bursts, or beats wider than the bus, are rejected.
  assign aw_bad  = (AWBURST > BURST_INCR) || (int'(AWSIZE) > MAX_SIZE);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      issued_q    <= '0;
      completed_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_last_q  <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_last_q  <= cmd_last_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    issued_d    = issued_q;
    completed_d = completed_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_last_d  = cmd_last_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;

    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end

    // Completions beyond the number of issued commands are spurious and dropped.
    if (cmp_hit) begin
      if (completed_q < issued_q) begin
        completed_d = completed_q + 9'd1;
      end
      if (cmp_nack) begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          addr_d      = AWADDR;
          size_d      = AWSIZE;
          burst_d     = AWBURST;
          err_d       = aw_bad;
          issued_d    = '0;
          completed_d = '0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          // Beats of a rejected burst are consumed but never forwarded.
          if (!err_q) begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = addr_q;
            cmd_data_d  = WADATA;
            cmd_last_d  = WLAST;
            issued_d    = issued_q + ((issued_q != BEAT_MAX) ? 9'd1 : 9'd0);
            if (burst_q == BURST_INCR) begin
              addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
            end
          end
          if (WLAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // completed_d already includes a completion arriving this cycle.
        if (!cmd_valid_q && (completed_d == issued_q)) begin
          bvalid_d = 1'b1;
          bresp_d  = err_d ? RESP_SLVERR : RESP_OKAY;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // AWREADY is registered so it rises one edge after reset release or B handshake.
  assign awready_d = (state_d == IDLE);

  assign AWREADY   = awready_q;
  assign WREADY    = wready;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_last  = cmd_last_q;

endmodule

// File: tb/tb_axi_wr_slave_fe.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_slave_fe
//
// Directed bench for axi_wr_slave_fe. Stimulus pushes the expected commands
// and B responses into queues; a monitor pops and compares them whenever the
// DUT presents a command or response handshake. A small engine model drives
// cmd_ready and returns one completion pulse per accepted command.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_wr_slave_fe;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic        WLAST = 1'b0;
  logic [31:0] WADATA = '0;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [1:0]  BRESP;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_last;
  logic        cmp_valid = 1'b0;
  logic        cmp_nack = 1'b0;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic last; } cmd_t;
  typedef struct { logic [1:0] resp; int ncomp; } b_t;

  cmd_t exp_cmd[$];
  b_t   exp_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int served   = 0;
  int tot_comp = 0;
  int last_tot = 0;
  int nack_at  = -1;
  bit rdy_toggle = 1'b0;

  axi_wr_slave_fe #(
    .ADDR_WIDTH(32), .WDATA_WIDTH(32), .SIZE(3), .BURST_SIZE(2), .RESPONSE_WIDTH(2)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WADATA(WADATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_last(cmd_last), .cmp_valid(cmp_valid), .cmp_nack(cmp_nack)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake did not occur within the cycle budget", name);
  endtask

  // Engine model: cmd_ready pattern and one completion per accepted command.
  initial begin
    forever begin
      @(posedge ACLK); #1;
      cmd_ready = rdy_toggle ? !cmd_ready : 1'b1;
      cmp_valid = 1'b0;
      cmp_nack  = 1'b0;
      if (!ARESETn) begin
        served = hs_cnt;
      end else if (served < hs_cnt) begin
        served++;
        cmp_valid = 1'b1;
        cmp_nack  = (tot_comp == nack_at);
        tot_comp++;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    cmd_t        ec;
    b_t          eb;
    bit          prev_stall = 1'b0;
    bit          prev_bstall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [1:0]  prev_bresp = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        last_tot    = tot_comp;
        prev_stall  = 1'b0;
        prev_bstall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("cmd_hold_valid", 64'(cmd_valid), 64'd1);
          chk("cmd_hold_addr", 64'(cmd_addr), 64'(prev_addr));
          chk("cmd_hold_data", 64'(cmd_data), 64'(prev_data));
          chk("cmd_hold_last", 64'(cmd_last), 64'(prev_last));
        end
        if (cmd_valid && !cmd_ready) chk("wready_when_full", 64'(WREADY), 64'd0);
        if (prev_bstall) begin
          chk("b_hold_valid", 64'(BVALID), 64'd1);
          chk("b_hold_resp", 64'(BRESP), 64'(prev_bresp));
        end
        if (cmd_valid && cmd_ready) begin
          hs_cnt++;
          if (exp_cmd.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_cmd: got addr 0x%0h data 0x%0h, required no command", cmd_addr, cmd_data);
          end else begin
            ec = exp_cmd.pop_front();
            chk("cmd_addr", 64'(cmd_addr), 64'(ec.addr));
            chk("cmd_data", 64'(cmd_data), 64'(ec.data));
            chk("cmd_last", 64'(cmd_last), 64'(ec.last));
          end
        end
        if (BVALID && BREADY) begin
          if (exp_b.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_b: got BRESP 0x%0h, required no response", BRESP);
          end else begin
            eb = exp_b.pop_front();
            chk("bresp", 64'(BRESP), 64'(eb.resp));
            chk("b_after_completions", 64'(tot_comp - last_tot), 64'(eb.ncomp));
          end
          last_tot = tot_comp;
        end
        prev_stall  = cmd_valid && !cmd_ready;
        prev_addr   = cmd_addr;
        prev_data   = cmd_data;
        prev_last   = cmd_last;
        prev_bstall = BVALID && !BREADY;
        prev_bresp  = BRESP;
      end
    end
  end

  task automatic push_b(input logic [1:0] resp, input int n);
    b_t e;
    e.resp  = resp;
    e.ncomp = n;
    exp_b.push_back(e);
  endtask

  task automatic aw(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
    bit ok = 1'b0;
    AWADDR = a; AWSIZE = s; AWBURST = b; AWVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (AWREADY) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("aw_handshake");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic last, input logic [31:0] ea, input bit fwd);
    bit   ok = 1'b0;
    cmd_t e;
    if (fwd) begin
      e.addr = ea; e.data = d; e.last = last;
      exp_cmd.push_back(e);
    end
    WADATA = d; WLAST = last; WVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (WREADY) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("w_handshake");
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic wait_b_done();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (exp_b.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("b_response");
    @(posedge ACLK); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_awready"},   64'(AWREADY),   64'd0);
    chk({tag, "_wready"},    64'(WREADY),    64'd0);
    chk({tag, "_bvalid"},    64'(BVALID),    64'd0);
    chk({tag, "_bresp"},     64'(BRESP),     64'd0);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmd_addr"},  64'(cmd_addr),  64'd0);
    chk({tag, "_cmd_data"},  64'(cmd_data),  64'd0);
    chk({tag, "_cmd_last"},  64'(cmd_last),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    // Reset values and AWREADY rising one edge after release.
    repeat (3) @(negedge ACLK);
    chk_reset_outs("rst");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("awready_before_edge", 64'(AWREADY), 64'd0);
    @(negedge ACLK);
    chk("awready_after_rst", 64'(AWREADY), 64'd1);
    @(posedge ACLK); #1;

    // INCR, 4 beats of 4 bytes from 0x100.
    push_b(2'b00, 4);
    aw(32'h100, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'hA0 + i, (i == 3), 32'h100 + 4 * i, 1'b1);
    wait_b_done();

    // FIXED, 3 beats at 0x40 with cmd_ready toggling.
    rdy_toggle = 1'b1;
    push_b(2'b00, 3);
    aw(32'h40, 3'd2, 2'b00);
    w_beat(32'h11, 1'b0, 32'h40, 1'b1);
    w_beat(32'h22, 1'b0, 32'h40, 1'b1);
    w_beat(32'h33, 1'b1, 32'h40, 1'b1);
    wait_b_done();
    rdy_toggle = 1'b0;

    // WRAP burst: beats consumed, nothing forwarded, SLVERR.
    push_b(2'b10, 0);
    aw(32'h80, 3'd2, 2'b10);
    w_beat(32'h55, 1'b0, 32'h0, 1'b0);
    w_beat(32'h66, 1'b1, 32'h0, 1'b0);
    wait_b_done();

    // Beat wider than the 32-bit bus: SLVERR, nothing forwarded.
    push_b(2'b10, 0);
    aw(32'h90, 3'd3, 2'b01);
    w_beat(32'h77, 1'b1, 32'h0, 1'b0);
    wait_b_done();

    // INCR 3 beats, NACK on the 2nd completion; SLVERR after the 3rd.
    nack_at = tot_comp + 1;
    push_b(2'b10, 3);
    aw(32'h200, 3'd2, 2'b01);
    w_beat(32'hB0, 1'b0, 32'h200, 1'b1);
    w_beat(32'hB1, 1'b0, 32'h204, 1'b1);
    w_beat(32'hB2, 1'b1, 32'h208, 1'b1);
    wait_b_done();
    nack_at = -1;

    // BREADY held low: response stable, no new AW accepted.
    BREADY = 1'b0;
    push_b(2'b00, 2);
    aw(32'h300, 3'd1, 2'b01);
    w_beat(32'h1234, 1'b0, 32'h300, 1'b1);
    w_beat(32'h5678, 1'b1, 32'h302, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (BVALID) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("bvalid_rise");
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bstall_bvalid", 64'(BVALID), 64'd1);
      chk("bstall_bresp", 64'(BRESP), 64'd0);
      chk("bstall_awready", 64'(AWREADY), 64'd0);
    end
    @(posedge ACLK); #1;
    BREADY = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("awready_after_b", 64'(AWREADY), 64'd1);
    chk("bvalid_after_b", 64'(BVALID), 64'd0);
    @(posedge ACLK); #1;

    // Reset pulsed mid-burst, then a fresh burst.
    aw(32'h500, 3'd2, 2'b01);
    w_beat(32'hC0, 1'b0, 32'h500, 1'b1);
    w_beat(32'hC1, 1'b0, 32'h504, 1'b1);
    ARESETn = 1'b0;
    exp_cmd.delete();
    @(negedge ACLK);
    chk_reset_outs("midrst");
    repeat (2) @(negedge ACLK);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("no_b_after_rst", 64'(BVALID), 64'd0);
    end
    @(posedge ACLK); #1;
    push_b(2'b00, 2);
    aw(32'h600, 3'd2, 2'b01);
    w_beat(32'hD0, 1'b0, 32'h600, 1'b1);
    w_beat(32'hD1, 1'b1, 32'h604, 1'b1);
    wait_b_done();

    repeat (3) @(negedge ACLK);
    chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
